rand_arbiter: RTL

Shares the 8-bit `rand_bit` byte from the `rng` block between two requesters: port A, the CPU executing CXNN, and port B, a debug/self-test requester. It arbitrates round-robin and applies the requester's mask (`rand & NN`). It enforces a minimum stir interval between samples so that consecutive grants never return bytes from adjacent RNG cycles. It sits between `rng` and the CPU execute stage, with the same `clk_in` domain.

---
 rtl/rand_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/rand_arbiter.sv
// rand_arbiter
// Shares the 8-bit byte from the rng block between two requesters. Port A is
// the CPU executing CXNN and port B is a debug/self-test requester. Each grant
// returns (rand_bit & mask) for the winning port. Arbitration is round-robin.
// A minimum stir interval between grant edges ensures that two consecutive
// grants never return bytes from adjacent RNG cycles.
//
// Handshake: req_x is a level request that the requester holds until ack_x.
// mask_x must be stable while req_x is high. ack_x is a one-cycle pulse.
// rand_out is valid in the cycle where ack_x is high, and it holds its value
// until the next grant. Requests are evaluated only in IDLE, and only once
// the stir gap has elapsed. A request dropped before its grant is forgotten.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   rand_bit     raw byte from rng, changes every cycle
//   req_a/mask_a request and AND mask, port A (CPU)
//   req_b/mask_b request and AND mask, port B (debug)
//   ack_a/ack_b  one-cycle grant pulses, never high together
//   rand_out     masked random byte, held between grants
//   busy         high while a new grant is not possible
//   sample_count number of grants issued, wraps at 16 bits
//   state_dbg    FSM state (1 = ACK), for observation only
module rand_arbiter #(
  parameter int unsigned STIR_CYCLES = 4  // legal range 2..15
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  rand_bit,
  input  logic        req_a,
  input  logic [7:0]  mask_a,
  input  logic        req_b,
  input  logic [7:0]  mask_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [7:0]  rand_out,
  output logic        busy,
  output logic [15:0] sample_count,
  output logic        state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [3:0] STIR = 4'(STIR_CYCLES);

  state_t     state;
  logic [3:0] gap_cnt;  // cycles since the last grant edge, saturating at STIR
  logic       prio_b;   // 1: B wins a tie, 0: A wins a tie

  logic       grant;
  logic       win_b;
  logic [7:0] win_mask;

  always_comb begin
    grant    = (state == IDLE) && (gap_cnt >= STIR) && (req_a || req_b);
    // A lone requester wins. When both request, prio decides, not age.
    win_b    = req_b && (!req_a || prio_b);
    win_mask = win_b ? mask_b : mask_a;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      gap_cnt      <= STIR;  // saturated, so the first request is served at once
      prio_b       <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      rand_out     <= 8'h00;
      sample_count <= 16'h0000;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;

      if (grant)
        gap_cnt <= 4'd1;
      else if (gap_cnt < STIR)
        gap_cnt <= gap_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (grant) begin
            rand_out     <= rand_bit & win_mask;
            ack_a        <= !win_b;
            ack_b        <= win_b;
            sample_count <= sample_count + 16'd1;
            prio_b       <= !win_b;  // the loser gets priority next time
            state        <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == ACK) || (gap_cnt < STIR);
  assign state_dbg = (state == ACK);

endmodule
